// File: rtl/timer_set_ctrl.sv
// Front-panel controller for a chain of BCD timer digit counters: button edges -> presets, run control, expiry.
// Optional TIMER_SET_AUTOREPEAT_EN adds hold-to-repeat on inc/dec while editing.
module timer_set_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter logic [3:0]  MAX_DIGIT   = 4'd9,
  parameter logic [15:0] REPEAT_DLY  = 16'd500,
  parameter logic [15:0] REPEAT_RATE = 16'd100
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  btn_run,
  input  logic                  btn_clear,
  input  logic                  dir_sel,
  input  logic [4*DIGITS-1:0]   Count_in,
  output logic [4*DIGITS-1:0]   Init_value,
  output logic                  set_time,
  output logic                  start,
  output logic                  pause,
  output logic                  stop,
  output logic                  UpOrDown,
  output logic [2:0]            sel_digit,
  output logic [1:0]            state_o,
  output logic                  expired
);

  typedef enum logic [1:0] {
    ST_SET  = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [2:0] LAST_SEL = 3'(DIGITS - 1);

  state_t     state_q, state_d;
  logic [3:0] init_q [DIGITS];
  logic [3:0] init_d [DIGITS];
  logic [2:0] sel_q, sel_d;
  logic       set_time_q, set_time_d;
  logic       start_q, start_d;
  logic       pause_q, pause_d;
  logic       stop_q, stop_d;
  logic       updown_q, updown_d;
  logic       expired_q, expired_d;
  logic       first_q, first_d;
  logic [4:0] prev_q, prev_d;

  logic       e_run, e_clear, e_mode, e_inc, e_dec;
  logic       presets_zero;
  logic       run_go;
  logic       rpt_step;
  logic [3:0] cur_digit;

  assign e_run   = btn_run   & ~prev_q[4];
  assign e_clear = btn_clear & ~prev_q[3];
  assign e_mode  = btn_mode  & ~prev_q[2];
  assign e_inc   = btn_inc   & ~prev_q[1];
  assign e_dec   = btn_dec   & ~prev_q[0];

`ifdef TIMER_SET_AUTOREPEAT_EN
  logic [15:0] hold_q, hold_d;
  logic        rep_q, rep_d;

  // rep_q selects the interval: REPEAT_DLY before the first repeat, REPEAT_RATE after.
  always_comb begin
    hold_d   = '0;
    rep_d    = 1'b0;
    rpt_step = 1'b0;
    if (state_q == ST_SET && (btn_inc ^ btn_dec)) begin
      if (e_inc | e_dec) begin
        hold_d = 16'd1;
      end else if ((!rep_q && hold_q == REPEAT_DLY) || (rep_q && hold_q == REPEAT_RATE)) begin
        rpt_step = 1'b1;
        hold_d   = 16'd1;
        rep_d    = 1'b1;
      end else begin
        hold_d = hold_q + 16'd1;
        rep_d  = rep_q;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DLY, REPEAT_RATE};
  assign rpt_step      = 1'b0;
`endif

  always_comb begin
    presets_zero = 1'b1;
    cur_digit    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (init_q[i] != '0) presets_zero = 1'b0;
      if (sel_q == 3'(i)) cur_digit = init_q[i];
    end
  end

  // A refused run edge (down-count from all-zero presets) lets lower-priority edges through.
  assign run_go = e_run && (updown_q || !presets_zero);

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    sel_d      = sel_q;
    set_time_d = 1'b0;
    start_d    = start_q;
    pause_d    = pause_q;
    stop_d     = stop_q;
    updown_d   = updown_q;
    expired_d  = expired_q;
    first_d    = 1'b0;
    prev_d     = {btn_run, btn_clear, btn_mode, btn_inc, btn_dec};

    unique case (state_q)
      ST_SET: begin
        updown_d = dir_sel;
        if (run_go) begin
          state_d = ST_RUN;
          start_d = 1'b1;
          pause_d = 1'b0;
          first_d = 1'b1;
        end else if (e_clear) begin
          for (int unsigned i = 0; i < DIGITS; i++) init_d[i] = '0;
          sel_d      = '0;
          set_time_d = 1'b1;
        end else if (e_mode) begin
          sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 3'd1;
        end else if ((e_inc ^ e_dec) || rpt_step) begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel_q == 3'(i)) begin
              if ((e_inc ^ e_dec) ? e_inc : btn_inc)
                init_d[i] = (cur_digit == MAX_DIGIT) ? '0 : cur_digit + 4'd1;
              else
                init_d[i] = (cur_digit == '0) ? MAX_DIGIT : cur_digit - 4'd1;
            end
          end
          set_time_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (e_run) begin
          state_d = ST_HOLD;
          pause_d = 1'b1;
        end else if (e_clear) begin
          state_d    = ST_SET;
          start_d    = 1'b0;
          pause_d    = 1'b0;
          set_time_d = 1'b1;
        end else if (!first_q && !updown_q && Count_in == '0) begin
          state_d   = ST_DONE;
          start_d   = 1'b0;
          stop_d    = 1'b1;
          expired_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (e_run) begin
          state_d = ST_RUN;
          pause_d = 1'b0;
          first_d = 1'b1;
        end else if (e_clear) begin
          state_d    = ST_SET;
          start_d    = 1'b0;
          pause_d    = 1'b0;
          set_time_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (e_clear) begin
          state_d    = ST_SET;
          stop_d     = 1'b0;
          expired_d  = 1'b0;
          set_time_d = 1'b1;
        end
      end
      default: state_d = ST_SET;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SET;
      for (int unsigned i = 0; i < DIGITS; i++) init_q[i] <= '0;
      sel_q      <= '0;
      set_time_q <= 1'b0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      stop_q     <= 1'b0;
      updown_q   <= 1'b1;
      expired_q  <= 1'b0;
      first_q    <= 1'b0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      sel_q      <= sel_d;
      set_time_q <= set_time_d;
      start_q    <= start_d;
      pause_q    <= pause_d;
      stop_q     <= stop_d;
      updown_q   <= updown_d;
      expired_q  <= expired_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
    end
  end

  always_comb begin
    Init_value = '0;
    for (int unsigned i = 0; i < DIGITS; i++) Init_value[4*i +: 4] = init_q[i];
  end

  assign set_time  = set_time_q;
  assign start     = start_q;
  assign pause     = pause_q;
  assign stop      = stop_q;
  assign UpOrDown  = updown_q;
  assign sel_digit = sel_q;
  assign state_o   = state_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Scoreboard bench for timer_set_ctrl: expected outputs queued per driven cycle, compared after the clock edge.
module tb_timer_set_ctrl;

  localparam int unsigned DIGITS = 4;
`ifdef TIMER_SET_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic                Clk = 1'b0;
  logic                reset;
  logic                btn_mode, btn_inc, btn_dec, btn_run, btn_clear;
  logic                dir_sel;
  logic [4*DIGITS-1:0] Count_in;
  logic [4*DIGITS-1:0] Init_value;
  logic                set_time, start, pause, stop, UpOrDown, expired;
  logic [2:0]          sel_digit;
  logic [1:0]          state_o;

  always #5 Clk = ~Clk;

  timer_set_ctrl #(
    .DIGITS      (DIGITS),
    .MAX_DIGIT   (4'd9),
    .REPEAT_DLY  (16'd5),
    .REPEAT_RATE (16'd2)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_run    (btn_run),
    .btn_clear  (btn_clear),
    .dir_sel    (dir_sel),
    .Count_in   (Count_in),
    .Init_value (Init_value),
    .set_time   (set_time),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .UpOrDown   (UpOrDown),
    .sel_digit  (sel_digit),
    .state_o    (state_o),
    .expired    (expired)
  );

  typedef struct packed {
    logic [15:0] init;
    logic        set_time;
    logic        start;
    logic        pause;
    logic        stop;
    logic        updown;
    logic [2:0]  sel;
    logic [1:0]  st;
    logic        expired;
  } exp_t;

  localparam exp_t RESET_EXP = '{init: 16'h0, set_time: 1'b0, start: 1'b0, pause: 1'b0,
                                 stop: 1'b0, updown: 1'b1, sel: 3'd0, st: 2'd0, expired: 1'b0};

  exp_t        ex;
  exp_t        sb_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check_eq("Init_value", 32'(Init_value), 32'(e.init));
    check_eq("set_time",   32'(set_time),   32'(e.set_time));
    check_eq("start",      32'(start),      32'(e.start));
    check_eq("pause",      32'(pause),      32'(e.pause));
    check_eq("stop",       32'(stop),       32'(e.stop));
    check_eq("UpOrDown",   32'(UpOrDown),   32'(e.updown));
    check_eq("sel_digit",  32'(sel_digit),  32'(e.sel));
    check_eq("state_o",    32'(state_o),    32'(e.st));
    check_eq("expired",    32'(expired),    32'(e.expired));
  endtask

  task automatic tick();
    exp_t e;
    sb_q.push_back(ex);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    compare_outputs(e);
    ex.set_time = 1'b0;
  endtask

  // 0=inc 1=dec 2=mode 3=run 4=clear
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_inc   = v;
      1: btn_dec   = v;
      2: btn_mode  = v;
      3: btn_run   = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick();
    set_btn(which, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    {btn_mode, btn_inc, btn_dec, btn_run, btn_clear} = '0;
    dir_sel  = 1'b1;
    Count_in = '0;
    ex       = RESET_EXP;
    #2;
    tick();
    reset = 1'b0;
    tick();

    // preset editing on digit 0, then wrap checks on digit 1
    for (int k = 1; k <= 3; k++) begin
      ex.init[3:0] = 4'(k); ex.set_time = 1'b1; press(0);
    end
    ex.init[3:0] = 4'd2; ex.set_time = 1'b1; press(1);
    check_eq("init_after_edits", 32'(Init_value), 32'h0002);
    ex.sel = 3'd1; press(2);
    ex.init[7:4] = 4'd9; ex.set_time = 1'b1; press(1);
    check_eq("dec_wrap_digit1", 32'(Init_value), 32'h0092);
    ex.init[7:4] = 4'd0; ex.set_time = 1'b1; press(0);
    for (int k = 2; k <= 5; k++) begin
      ex.sel = 3'(k % 4); press(2);
    end
    check_eq("sel_after_4_modes", 32'(sel_digit), 32'd1);
    btn_inc = 1'b1; btn_dec = 1'b1; tick();
    btn_inc = 1'b0; btn_dec = 1'b0; tick();
    ex.init = '0; ex.sel = 3'd0; ex.set_time = 1'b1; press(4);

    // down-count to expiry
    for (int k = 1; k <= 3; k++) begin
      ex.init[3:0] = 4'(k); ex.set_time = 1'b1; press(0);
    end
    dir_sel = 1'b0; ex.updown = 1'b0; tick();
    Count_in = 16'd3; ex.st = 2'd1; ex.start = 1'b1; press(3);
    Count_in = 16'd2; tick();
    Count_in = 16'd1; tick();
    Count_in = 16'd0; ex.st = 2'd3; ex.start = 1'b0; ex.stop = 1'b1; ex.expired = 1'b1; tick();
    press(3);
    press(0);
    ex.st = 2'd0; ex.stop = 1'b0; ex.expired = 1'b0; ex.set_time = 1'b1; press(4);

    // pause/resume with the expiry mask on the first resumed cycle
    Count_in = 16'd5; ex.st = 2'd1; ex.start = 1'b1; press(3);
    ex.st = 2'd2; ex.pause = 1'b1; press(3);
    Count_in = 16'd0; tick();
    ex.st = 2'd1; ex.pause = 1'b0; press(3);
    ex.st = 2'd3; ex.start = 1'b0; ex.stop = 1'b1; ex.expired = 1'b1; tick();
    ex.st = 2'd0; ex.stop = 1'b0; ex.expired = 1'b0; ex.set_time = 1'b1; press(4);

    // clear from HOLD keeps presets
    Count_in = 16'd5; ex.st = 2'd1; ex.start = 1'b1; press(3);
    ex.st = 2'd2; ex.pause = 1'b1; press(3);
    ex.st = 2'd0; ex.start = 1'b0; ex.pause = 1'b0; ex.set_time = 1'b1; press(4);
    check_eq("presets_kept", 32'(Init_value), 32'h0003);

    // all-zero presets: refused when counting down, accepted when counting up
    ex.init = '0; ex.set_time = 1'b1; press(4);
    Count_in = 16'd0; press(3);
    dir_sel = 1'b1; ex.updown = 1'b1; tick();
    ex.st = 2'd1; ex.start = 1'b1; press(3);
    repeat (5) tick();
    ex.st = 2'd0; ex.start = 1'b0; ex.set_time = 1'b1; press(4);

    // hold inc for 10 cycles
    btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || (AR && (k == 5 || k == 7 || k == 9))) begin
        ex.init[3:0] = ex.init[3:0] + 4'd1; ex.set_time = 1'b1;
      end
      tick();
    end
    btn_inc = 1'b0; tick();
    check_eq("held_inc_digit", 32'(Init_value[3:0]), AR ? 32'd4 : 32'd1);

    // asynchronous reset while running
    Count_in = 16'd5; ex.st = 2'd1; ex.start = 1'b1; press(3);
    reset = 1'b1;
    #1;
    ex = RESET_EXP;
    compare_outputs(ex);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_set_ctrl.md
# timer_set_ctrl

Front-panel controller that drives a chain of `DIGITS` BCD timer digit counters through their control pins. It turns debounced push-buttons into per-digit preset values, a `set_time` reload pulse, `start`/`pause`/`stop` levels and the count direction. It also monitors the chained `Count` outputs so it can declare expiry of a down-count. It sits between the button synchroniser/debouncer and the digit counters.

## Interface
Parameters:
- `DIGITS`, 4, number of digits driven (1..8).
- `MAX_DIGIT`, 4'd9, highest digit value; must equal the counters' `N`.
- `REPEAT_DLY`, 16'd500, hold cycles before the first auto-repeat step.
- `REPEAT_RATE`, 16'd100, cycles between subsequent auto-repeat steps.

Ports:
- `Clk`  in  1  clock.
- `reset`  in  1  async, active-high; reset reset, asynchronous, active-high; clock Clk.
- `btn_mode`  in  1  level; rising edge advances the selected digit.
- `btn_inc` / `btn_dec`  in  1  level; rising edge steps the selected digit up or down.
- `btn_run`  in  1  level; rising edge starts, pauses or resumes.
- `btn_clear`  in  1  level; rising edge aborts and zeroes the presets.
- `dir_sel`  in  1  1 = up, 0 = down; sampled in SET only.
- `Count_in`  in  4*DIGITS  concatenated digit counter outputs; digit 0 is LSBs.
- `Init_value`  out  4*DIGITS  per-digit presets.
- `set_time`  out  1  one-cycle reload pulse.
- `start`, `pause`, `stop`  out  1  counter control levels.
- `UpOrDown`  out  1  latched direction.
- `sel_digit`  out  3  index of the digit being edited.
- `state_o`  out  2  SET=00, RUN=01, HOLD=10, DONE=11.
- `expired`  out  1  down-count reached zero.

## Operation
- Buttons are already synchronised. Each button gets an internal prev-register (reset value 0). An edge is `btn & ~prev`.
- Priority within one cycle: run > clear > mode > inc/dec. If inc and dec edges occur together, the digit does not change.
- SET:
  - inc: `Init_value[sel]` increments; `MAX_DIGIT` wraps to 0.
  - dec: `Init_value[sel]` decrements; 0 wraps to `MAX_DIGIT`.
  - mode: `sel_digit` increments, wrapping from `DIGITS-1` to 0.
  - clear: all presets go to 0 and `sel_digit` goes to 0.
  - Every preset change or clear produces a `set_time` pulse.
  - `UpOrDown` <= `dir_sel` every cycle while in SET.
  - run: go to RUN with `start`=1, `pause`=0. Exception: if `UpOrDown`=0 and all presets are 0, the run edge is ignored.
- RUN:
  - run: go to HOLD with `pause`=1; `start` stays 1.
  - clear: go to SET with `start`=0 and a `set_time` pulse; presets are retained.
  - If `UpOrDown`=0 and `Count_in` is all zeros: go to DONE. The check is masked in the first RUN cycle after entry from SET or HOLD.
  - When `UpOrDown`=1, the block never expires.
- HOLD:
  - run: go to RUN with `pause`=0.
  - clear: same action as clear in RUN.
- DONE:
  - `stop`=1, `start`=0, `expired`=1.
  - clear: go to SET with `stop`=0, `expired`=0 and a `set_time` pulse.
  - All other buttons are ignored.
- mode, inc and dec are ignored outside SET.

## Timing
- All outputs are registered.
- Reset values: state SET, `Init_value`=0, `sel_digit`=0, `set_time`=0, `start`=0, `pause`=0, `stop`=0, `UpOrDown`=1, `expired`=0.
- An edge sampled in cycle N produces the new state/outputs from cycle N+1.
- `set_time` is high for exactly cycle N+1, coincident with the new `Init_value`.
- Back-to-back edges produce back-to-back pulses.
- Expiry: `Count_in`=0 sampled in cycle M sets `stop`/`expired` in cycle M+1.
- Reset mid-RUN returns to the reset values immediately; no `set_time` pulse is generated.

## Configuration
- `TIMER_SET_AUTOREPEAT_EN` defined:
  - In SET, while inc (or dec) stays high after its edge, a 16-bit hold counter runs.
  - At `REPEAT_DLY` cycles the block issues one extra step, then one step every `REPEAT_RATE` cycles while the button is held.
  - Each step pulses `set_time`.
  - The counter clears on release, on leaving SET, or if both buttons are high.
- Not defined: only edges step; the hold counter and the `REPEAT_*` parameters are unused.

## Test plan
- Reset, then 3 inc edges on digit 0 and 1 dec edge: `Init_value`=16'h0002 with 4 `set_time` pulses. Then 1 dec edge from 0 on digit 1 (after a mode edge): digit 1 = 9.
- DIGITS=4: 4 mode edges return `sel_digit` to 0. Simultaneous inc+dec: no change and no `set_time`.
- Preset 16'h0003, `dir_sel`=0, run; drive `Count_in` 2,1,0: `expired` and `stop` rise one cycle after 0, `start` falls. Clear edge: SET with `set_time` pulse.
- RUN, then run edge: HOLD with `pause`=1, `start`=1. Run edge again: `pause`=0. `Count_in`=0 during the first resumed cycle does not expire.
- All presets 0, down mode, run edge: stays in SET. Same with `dir_sel`=1: enters RUN and never expires.
- Macro defined, REPEAT_DLY=5, REPEAT_RATE=2, inc held 10 cycles: steps at edge, +5, +7, +9 (digit = 4). Macro undefined: digit = 1.
